// File: rtl/alu_seq_pkg.sv
// Shared state codes, default widths and flag bit positions for the ALU operand sequencer.
// Pure declarations; no latency or backpressure of its own.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OPW   = 3;
    localparam int DEF_CNTW  = 8;

    // Bit positions inside the two-bit ALU flag vector {carry, overflow}
    localparam int CCR_CARRY = 1;
    localparam int CCR_OVF   = 0;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: pulse is high for one cycle when in rises, combinational from the current sample.
// No backpressure; history resets to 1 so a level held across reset release is not seen as an edge.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= in;
        end
    end

    assign pulse = in & ~r_hist;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences operand A, operand B and operator entry for an external ALU, then captures its result; valid 2 cycles after operator press.
// No backpressure: one button press advances one step; clr aborts back to operand-A entry.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enter,
    input  logic             clr,
    input  logic             chain,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_ccr,
    output logic [WIDTH-1:0] n1,
    output logic [WIDTH-1:0] n2,
    output logic [OPW-1:0]   operator,
    output logic [WIDTH-1:0] result_q,
    output logic [1:0]       ccr_q,
    output logic             valid,
    output logic             done,
    output logic [2:0]       state_o,
    output logic [CNTW-1:0]  op_count
);

    logic             w_press;
    state_t           r_state;
    logic [WIDTH-1:0] r_n1;
    logic [WIDTH-1:0] r_n2;
    logic [OPW-1:0]   r_operator;
    logic [WIDTH-1:0] r_result_q;
    logic [1:0]       r_ccr_q;
    logic             r_valid;
    logic             r_done;
    logic [CNTW-1:0]  r_op_count;

    edge_rise u_enter_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (enter),
        .pulse (w_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_A;
            r_n1       <= '0;
            r_n2       <= '0;
            r_operator <= '0;
            r_result_q <= '0;
            r_ccr_q    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_valid <= 1'b0;
            // clr beats any press and also cancels an in-flight capture
            if (clr) begin
                r_state <= S_A;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_press) begin
                            r_n1    <= data_in;
                            r_state <= S_B;
                        end
                    end
                    S_B: begin
                        if (w_press) begin
                            r_n2    <= data_in;
                            r_state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (w_press) begin
                            r_operator <= data_in[OPW-1:0];
                            r_state    <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        r_result_q <= alu_result;
                        r_ccr_q    <= {alu_ccr[CCR_CARRY], alu_ccr[CCR_OVF]};
                        r_valid    <= 1'b1;
                        r_done     <= 1'b1;
                        r_op_count <= r_op_count + 1'b1;
                        r_state    <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (w_press) begin
                            r_done <= 1'b0;
                            if (chain) begin
                                r_n1    <= r_result_q;
                                r_state <= S_B;
                            end else begin
                                r_state <= S_A;
                            end
                        end
                    end
                    default: begin
                        r_done  <= 1'b0;
                        r_state <= S_A;
                    end
                endcase
            end
        end
    end

    assign n1       = r_n1;
    assign n2       = r_n2;
    assign operator = r_operator;
    assign result_q = r_result_q;
    assign ccr_q    = r_ccr_q;
    assign valid    = r_valid;
    assign done     = r_done;
    assign state_o  = r_state;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer against a transaction-level expectation model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       enter;
    logic       clr;
    logic       chain;
    logic [3:0] alu_result;
    logic [1:0] alu_ccr;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [2:0] operator;
    logic [3:0] result_q;
    logic [1:0] ccr_q;
    logic       valid;
    logic       done;
    logic [2:0] state_o;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    // Transaction-level expectations: what each register should hold after the last completed step
    int m_n1, m_n2, m_op, m_res, m_ccr, m_cnt;
    bit in_show;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .enter      (enter),
        .clr        (clr),
        .chain      (chain),
        .alu_result (alu_result),
        .alu_ccr    (alu_ccr),
        .n1         (n1),
        .n2         (n2),
        .operator   (operator),
        .result_q   (result_q),
        .ccr_q      (ccr_q),
        .valid      (valid),
        .done       (done),
        .state_o    (state_o),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press: enter high for one cycle, then released for one idle cycle
    task automatic press(input logic [3:0] d);
        data_in = d;
        enter   = 1'b1;
        tick();
        enter   = 1'b0;
        tick();
    endtask

    // One full randomized operation, optionally chained from the previous result
    task automatic do_op();
        int c, a, b, r, f, o;
        c = 0;
        if (in_show) begin
            c = int'($urandom_range(0, 1));
            chain = c[0];
            press(4'h0);
            chain = 1'b0;
            chk("show_exit_state", 32'(state_o), (c != 0) ? 32'd1 : 32'd0);
            chk("show_exit_done", 32'(done), 32'd0);
        end
        if (c != 0) begin
            m_n1 = m_res;
        end else begin
            a = int'($urandom_range(0, 15));
            press(4'(a));
            m_n1 = a;
        end
        b = int'($urandom_range(0, 15));
        press(4'(b));
        m_n2 = b;
        r = int'($urandom_range(0, 15));
        f = int'($urandom_range(0, 3));
        o = int'($urandom_range(0, 15));
        alu_result = 4'(r);
        alu_ccr    = 2'(f);
        press(4'(o));
        m_op  = o % 8;
        m_res = r;
        m_ccr = f;
        m_cnt = (m_cnt + 1) % 256;
        chk("op_valid", 32'(valid), 32'd1);
        chk("op_n1", 32'(n1), 32'(m_n1));
        chk("op_n2", 32'(n2), 32'(m_n2));
        chk("op_operator", 32'(operator), 32'(m_op));
        chk("op_result", 32'(result_q), 32'(m_res));
        chk("op_ccr", 32'(ccr_q), 32'(m_ccr));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        in_show = 1'b1;
    endtask

    initial begin
        rst = 1'b1; enter = 1'b1; clr = 1'b0; chain = 1'b0;
        data_in = 4'h0; alu_result = 4'hA; alu_ccr = 2'b10;

        // Reset with enter held high across release
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_n1", 32'(n1), 32'd0);
        chk("rst_n2", 32'(n2), 32'd0);
        chk("rst_operator", 32'(operator), 32'd0);
        chk("rst_result", 32'(result_q), 32'd0);
        chk("rst_ccr", 32'(ccr_q), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        enter = 1'b0;
        tick();

        // Basic operation 3, 5, 7 with stub ALU
        press(4'd3);
        chk("a_n1", 32'(n1), 32'd3);
        chk("a_state", 32'(state_o), 32'd1);
        press(4'd5);
        chk("b_n2", 32'(n2), 32'd5);
        chk("b_state", 32'(state_o), 32'd2);
        press(4'd7);
        chk("x_valid", 32'(valid), 32'd1);
        chk("x_state", 32'(state_o), 32'd4);
        chk("x_operator", 32'(operator), 32'd7);
        chk("x_result", 32'(result_q), 32'hA);
        chk("x_ccr", 32'(ccr_q), 32'd2);
        chk("x_count", 32'(op_count), 32'd1);
        chk("x_done", 32'(done), 32'd1);
        tick();
        chk("x_valid_pulse", 32'(valid), 32'd0);
        chk("x_done_held", 32'(done), 32'd1);

        // Chain from S_SHOW, then plain exit
        chain = 1'b1;
        press(4'h0);
        chain = 1'b0;
        chk("chain_n1", 32'(n1), 32'hA);
        chk("chain_state", 32'(state_o), 32'd1);
        chk("chain_done", 32'(done), 32'd0);
        press(4'd6);
        press(4'd2);
        chk("op2_count", 32'(op_count), 32'd2);
        press(4'h0);
        chk("nochain_state", 32'(state_o), 32'd0);
        chk("nochain_n1", 32'(n1), 32'hA);
        chk("nochain_n2", 32'(n2), 32'd6);
        chk("nochain_operator", 32'(operator), 32'd2);

        // Enter held 10 cycles gives a single capture
        data_in = 4'd9;
        enter   = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        tick();
        chk("hold_n1", 32'(n1), 32'd9);
        chk("hold_state", 32'(state_o), 32'd1);
        chk("hold_n2", 32'(n2), 32'd6);

        // clr during S_EXEC aborts the capture
        press(4'd1);
        data_in = 4'd5;
        enter   = 1'b1;
        tick();
        enter = 1'b0;
        chk("exec_state", 32'(state_o), 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_count", 32'(op_count), 32'd2);
        chk("abort_result", 32'(result_q), 32'hA);
        tick();
        chk("abort_valid_late", 32'(valid), 32'd0);

        // Press and clr together: clr wins
        clr = 1'b1;
        press(4'hC);
        clr = 1'b0;
        chk("clrpress_state", 32'(state_o), 32'd0);
        chk("clrpress_n1", 32'(n1), 32'd9);

        // Randomized operations up to the counter wrap
        m_n1 = 9; m_n2 = 1; m_op = 5; m_res = 10; m_ccr = 2; m_cnt = 2;
        in_show = 1'b0;
        for (int i = 0; i < 253; i++) do_op();
        chk("pre_wrap_count", 32'(op_count), 32'd255);
        do_op();
        chk("wrap_count", 32'(op_count), 32'd0);

        // Reset mid-operation discards partial entry
        press(4'h0);
        press(4'd5);
        chk("mid_n1", 32'(n1), 32'd5);
        rst   = 1'b1;
        enter = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_n1", 32'(n1), 32'd0);
        chk("midrst_result", 32'(result_q), 32'd0);
        chk("midrst_count", 32'(op_count), 32'd0);
        enter = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
